// File: rtl/clock_ratio_monitor.sv
// Clock ratio monitor: measures period/high time of a slow clk_in sampled in the clk domain,
// locks after consecutive in-tolerance periods and flags mismatch/stuck. Optional macro: CLKMON_SYNC_EN.
module clock_ratio_monitor #(
   parameter int N        = 4,
   parameter int CNT_W    = 8,
   parameter int TOL      = 0,
   parameter int LOCK_CNT = 3,
   parameter int TIMEOUT  = 4 * N
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             clk_in,
   input  logic             clr_fault,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_cnt,
   output logic             meas_valid,
   output logic             locked,
   output logic             mismatch,
   output logic             stuck,
   output logic             fault
);

   localparam int                MC_W    = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W:0]    N_X     = (CNT_W + 1)'(N);

   typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOCKED} state_t;

   state_t            state, state_n;
   logic              s_d, s, prev;
   logic              rise, fall;
   logic [CNT_W-1:0]  cnt, hcnt;
   logic [MC_W-1:0]   mc, mc_n;
   logic [CNT_W:0]    cnt_x, dev;
   logic              match, lock_hit, timeout, in_meas;
   logic              load_period, mv_n, mm_n, st_n, set_fault;

`ifdef CLKMON_SYNC_EN
   logic sync1, sync2;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= clk_in;
         sync2 <= sync1;
      end
   end

   assign s_d = sync2;
`else
   assign s_d = clk_in;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s    <= 1'b0;
         prev <= 1'b0;
      end else begin
         s    <= s_d;
         prev <= s;
      end
   end

   assign rise = s & ~prev;
   assign fall = ~s & prev;

   // Deviation is taken one bit wider than cnt so |cnt - N| never wraps.
   assign cnt_x    = {1'b0, cnt};
   assign dev      = (cnt_x >= N_X) ? (cnt_x - N_X) : (N_X - cnt_x);
   assign match    = (32'(dev) <= 32'(TOL));
   assign lock_hit = ((32'(mc) + 32'd1) == 32'(LOCK_CNT));
   assign timeout  = (32'(cnt) == 32'(TIMEOUT));
   assign in_meas  = (state == MEASURE) || (state == LOCKED);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         mc    <= '0;
      end else begin
         state <= state_n;
         mc    <= mc_n;
      end
   end

   always_comb begin
      state_n     = state;
      mc_n        = mc;
      load_period = 1'b0;
      mv_n        = 1'b0;
      mm_n        = 1'b0;
      st_n        = 1'b0;
      set_fault   = 1'b0;
      if (!en) begin
         state_n = IDLE;
         mc_n    = '0;
      end else begin
         case (state)
            IDLE: state_n = ARM;
            ARM: begin
               if (rise) begin
                  state_n = MEASURE;
                  mc_n    = '0;
               end
            end
            MEASURE: begin
               if (rise) begin
                  load_period = 1'b1;
                  mv_n        = 1'b1;
                  if (match) begin
                     if (lock_hit) begin
                        state_n = LOCKED;
                        mc_n    = '0;
                     end else begin
                        mc_n = mc + MC_W'(1);
                     end
                  end else begin
                     mc_n = '0;
                     mm_n = 1'b1;
                  end
               end else if (timeout) begin
                  st_n    = 1'b1;
                  state_n = ARM;
                  mc_n    = '0;
               end
            end
            LOCKED: begin
               if (rise) begin
                  load_period = 1'b1;
                  mv_n        = 1'b1;
                  if (!match) begin
                     mm_n      = 1'b1;
                     set_fault = 1'b1;
                     state_n   = MEASURE;
                     mc_n      = '0;
                  end
               end else if (timeout) begin
                  st_n      = 1'b1;
                  set_fault = 1'b1;
                  state_n   = ARM;
                  mc_n      = '0;
               end
            end
            default: begin
               state_n = IDLE;
               mc_n    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt  <= '0;
         hcnt <= '0;
      end else if (!en) begin
         cnt  <= '0;
         hcnt <= '0;
      end else begin
         if (rise)
            cnt <= CNT_ONE;
         else if (cnt != CNT_MAX)
            cnt <= cnt + CNT_ONE;
         if (rise)
            hcnt <= CNT_ONE;
         else if (s && (hcnt != CNT_MAX))
            hcnt <= hcnt + CNT_ONE;
      end
   end

   // A high time is only reported once a rise has been seen in the measuring states,
   // so partial pulses after arming or a restart never reach high_cnt.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         period     <= '0;
         high_cnt   <= '0;
         meas_valid <= 1'b0;
         mismatch   <= 1'b0;
         stuck      <= 1'b0;
         fault      <= 1'b0;
      end else begin
         if (load_period)
            period <= cnt;
         if (fall && en && in_meas)
            high_cnt <= hcnt;
         meas_valid <= mv_n;
         mismatch   <= mm_n;
         stuck      <= st_n;
         if (set_fault)
            fault <= 1'b1;
         else if (clr_fault)
            fault <= 1'b0;
      end
   end

   assign locked = (state == LOCKED);

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Bench for clock_ratio_monitor: four parameterisations share one stimulus stream and are
// compared every cycle against a timestamp-based reference model.
module tb_clock_ratio_monitor;

   localparam int NI = 4;
   localparam int M_OFF = 0, M_ARMED = 1, M_MEAS = 2, M_LOCK = 3;

   typedef struct {
      int n; int cmax; int tol; int lk; int tmo;
   } prm_t;

   typedef struct {
      int mode; int run; int last_rise; int period; int high;
      bit fault; bit mv; bit mm; bit st;
   } mdl_t;

   logic clk, rstn, en, clk_in, clr_fault;
   logic [7:0] op [NI];
   logic [7:0] oh [NI];
   logic ov [NI], ol [NI], om [NI], os [NI], of [NI];
   logic [2:0] p2, h2;

   prm_t prm [NI];
   mdl_t mdl [NI];
   int   total, bad, edge_no;
   bit   s_m, p_m;

   clock_ratio_monitor u0 (.clk(clk), .rstn(rstn), .en(en), .clk_in(clk_in), .clr_fault(clr_fault),
      .period(op[0]), .high_cnt(oh[0]), .meas_valid(ov[0]), .locked(ol[0]), .mismatch(om[0]),
      .stuck(os[0]), .fault(of[0]));

   clock_ratio_monitor #(.TOL(1)) u1 (.clk(clk), .rstn(rstn), .en(en), .clk_in(clk_in),
      .clr_fault(clr_fault), .period(op[1]), .high_cnt(oh[1]), .meas_valid(ov[1]), .locked(ol[1]),
      .mismatch(om[1]), .stuck(os[1]), .fault(of[1]));

   clock_ratio_monitor #(.CNT_W(3), .TIMEOUT(20)) u2 (.clk(clk), .rstn(rstn), .en(en), .clk_in(clk_in),
      .clr_fault(clr_fault), .period(p2), .high_cnt(h2), .meas_valid(ov[2]), .locked(ol[2]),
      .mismatch(om[2]), .stuck(os[2]), .fault(of[2]));

   clock_ratio_monitor #(.N(6)) u3 (.clk(clk), .rstn(rstn), .en(en), .clk_in(clk_in),
      .clr_fault(clr_fault), .period(op[3]), .high_cnt(oh[3]), .meas_valid(ov[3]), .locked(ol[3]),
      .mismatch(om[3]), .stuck(os[3]), .fault(of[3]));

   assign op[2] = {5'd0, p2};
   assign oh[2] = {5'd0, h2};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.mode = M_OFF; m.run = 0; m.last_rise = 0; m.period = 0; m.high = 0;
      m.fault = 0; m.mv = 0; m.mm = 0; m.st = 0;
      return m;
   endfunction

   // Elapsed time since the last rise is a timestamp difference, clipped to the counter range.
   function automatic mdl_t step(input mdl_t m_in, input prm_t p, input int j, input bit en_v,
                                 input bit clr_v, input bit rise, input bit fall);
      mdl_t m;
      int   el, dev;
      bit   setf;
      m = m_in;
      m.mv = 0; m.mm = 0; m.st = 0; setf = 0;
      if (!en_v) begin
         m.mode = M_OFF; m.run = 0;
      end else if (m.mode == M_OFF) begin
         m.mode = M_ARMED;
      end else if (m.mode == M_ARMED) begin
         if (rise) begin m.mode = M_MEAS; m.run = 0; m.last_rise = j; end
      end else begin
         el = j - m.last_rise;
         if (el > p.cmax) el = p.cmax;
         if (fall) m.high = el;
         if (rise) begin
            m.period = el; m.mv = 1; m.last_rise = j;
            dev = el - p.n;
            if (dev < 0) dev = -dev;
            if (dev <= p.tol) begin
               if (m.mode == M_MEAS) begin
                  m.run++;
                  if (m.run == p.lk) m.mode = M_LOCK;
               end
            end else begin
               m.mm = 1; m.run = 0;
               if (m.mode == M_LOCK) begin setf = 1; m.mode = M_MEAS; end
            end
         end else if (el == p.tmo) begin
            m.st = 1;
            if (m.mode == M_LOCK) setf = 1;
            m.mode = M_ARMED;
         end
      end
      if (setf) m.fault = 1;
      else if (clr_v) m.fault = 0;
      return m;
   endfunction

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s[%0d] cycle=%0d observed=%0d expected=%0d", tag, i, edge_no, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < NI; i++) begin
         chk("period", i, 32'(op[i]), 32'(mdl[i].period));
         chk("high_cnt", i, 32'(oh[i]), 32'(mdl[i].high));
         chk("meas_valid", i, 32'(ov[i]), 32'(mdl[i].mv));
         chk("locked", i, 32'(ol[i]), 32'(mdl[i].mode == M_LOCK));
         chk("mismatch", i, 32'(om[i]), 32'(mdl[i].mm));
         chk("stuck", i, 32'(os[i]), 32'(mdl[i].st));
         chk("fault", i, 32'(of[i]), 32'(mdl[i].fault));
      end
   endtask

   task automatic tick(input bit v);
      bit rise, fall;
      @(negedge clk);
      clk_in = v;
      @(posedge clk);
      edge_no++;
      rise = s_m & ~p_m;
      fall = ~s_m & p_m;
      for (int i = 0; i < NI; i++) begin
         if (!rstn) mdl[i] = mdl_reset();
         else mdl[i] = step(mdl[i], prm[i], edge_no, en, clr_fault, rise, fall);
      end
      p_m = rstn ? s_m : 1'b0;
      s_m = rstn ? clk_in : 1'b0;
      #1;
      check_all();
   endtask

   task automatic wave(input int hi, input int lo, input int reps);
      for (int r = 0; r < reps; r++) begin
         for (int k = 0; k < hi; k++) tick(1'b1);
         for (int k = 0; k < lo; k++) tick(1'b0);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(1'b0);
   endtask

   initial begin
      total = 0; bad = 0; edge_no = 0; s_m = 0; p_m = 0;
      prm[0] = '{n: 4, cmax: 255, tol: 0, lk: 3, tmo: 16};
      prm[1] = '{n: 4, cmax: 255, tol: 1, lk: 3, tmo: 16};
      prm[2] = '{n: 4, cmax: 7,   tol: 0, lk: 3, tmo: 20};
      prm[3] = '{n: 6, cmax: 255, tol: 0, lk: 3, tmo: 24};
      for (int i = 0; i < NI; i++) mdl[i] = mdl_reset();
      rstn = 1'b0; en = 1'b0; clk_in = 1'b0; clr_fault = 1'b0;

      #2;
      check_all();
      idle(3);
      rstn = 1'b1;
      en = 1'b1;
      idle(4);

      // Nominal divide-by-4: lock on the fourth rise.
      wave(2, 2, 8);
      chk("lock_n4", 0, 32'(ol[0]), 32'd1);
      chk("period_n4", 0, 32'(op[0]), 32'd4);
      chk("high_n4", 0, 32'(oh[0]), 32'd2);

      // Ratio change to 6 while locked.
      wave(3, 3, 6);
      chk("mis_lock", 0, 32'(ol[0]), 32'd0);
      chk("mis_fault", 0, 32'(of[0]), 32'd1);
      chk("mis_period", 0, 32'(op[0]), 32'd6);
      chk("relock_n6", 3, 32'(ol[3]), 32'd1);

      // clk_in stuck low.
      idle(30);
      chk("stuck_fault", 3, 32'(of[3]), 32'd1);
      chk("stuck_lock", 3, 32'(ol[3]), 32'd0);
      clr_fault = 1'b1;
      tick(1'b0);
      clr_fault = 1'b0;
      for (int i = 0; i < NI; i++) chk("clr_fault", i, 32'(of[i]), 32'd0);

      // Period 5 inside TOL=1, outside TOL=0.
      wave(3, 2, 6);
      chk("tol_lock", 1, 32'(ol[1]), 32'd1);
      chk("tol0_nolock", 0, 32'(ol[0]), 32'd0);

      en = 1'b0;
      idle(2);
      en = 1'b1;
      idle(2);
      // Period 10 saturates a 3-bit counter.
      wave(5, 5, 4);
      chk("sat_period", 2, 32'(op[2]), 32'd7);
      chk("sat_high", 2, 32'(oh[2]), 32'd5);

      // Asynchronous reset mid-lock, then relock from scratch.
      idle(2);
      wave(2, 2, 6);
      chk("pre_rst_lock", 0, 32'(ol[0]), 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) mdl[i] = mdl_reset();
      s_m = 0; p_m = 0;
      check_all();
      idle(3);
      rstn = 1'b1;
      wave(2, 2, 5);
      chk("relock_after_rst", 0, 32'(ol[0]), 32'd1);

      // Randomised waveforms with occasional disable, fault clear and long gaps.
      for (int w = 0; w < 250; w++) begin
         int hi, lo;
         hi = $urandom_range(1, 7);
         lo = ($urandom_range(0, 11) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 7);
         en = ($urandom_range(0, 39) != 0);
         clr_fault = ($urandom_range(0, 9) == 0);
         wave(hi, lo, 1);
      end
      clr_fault = 1'b0;
      en = 1'b1;
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
